// File: rtl/mux8_x0.sv
// 8:1 combinational mux cell with a clock-domain monitor on its output.
// Q is a pure combinational path (usable inside a ring oscillator); the
// monitor synchronizes Q, detects rising edges and counts them with a
// sticky overflow flag.
module mux8_x0 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  input  logic             F,
  input  logic             G,
  input  logic             H,
  input  logic             CNT_EN,
  input  logic             CNT_CLR,
  output logic             Q,
  output logic             Q_SYNC,
  output logic [2:0]       SEL_REG,
  output logic [CNT_W-1:0] EDGE_CNT,
  output logic             CNT_OVF
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]       data_w;
  logic [2:0]       sel_w;

  logic             sync1_q, sync1_d;
  logic             qsync_q, qsync_d;
  logic             qprev_q, qprev_d;
  logic [2:0]       sel_q,   sel_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic             rise_w;

  // Combinational mux: indexing keeps an X/Z select as X instead of
  // collapsing it to some default input, and no storage is inferred.
  assign data_w = {H, G, F, E, D, C, B, A};
  assign sel_w  = {S2, S1, S0};
  assign Q      = data_w[sel_w];

  // Rising edge of the synchronized output, seen one cycle after Q_SYNC rises.
  assign rise_w = qsync_q & ~qprev_q;

  // Next-state logic: synchronizer shift, select capture and edge counter.
  always_comb begin
    sync1_d = Q;
    qsync_d = sync1_q;
    qprev_d = qsync_q;
    sel_d   = sel_w;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (CNT_CLR) begin
      // Clear wins over a coincident increment or wrap.
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (CNT_EN && rise_w) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == '1) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Stage boundary: all monitor state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      qsync_q <= 1'b0;
      qprev_q <= 1'b0;
      sel_q   <= 3'b000;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      qsync_q <= qsync_d;
      qprev_q <= qprev_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q_SYNC   = qsync_q;
  assign SEL_REG  = sel_q;
  assign EDGE_CNT = cnt_q;
  assign CNT_OVF  = ovf_q;

endmodule

// File: tb/tb_mux8_x0.sv
// Self-checking bench for mux8_x0 (counter width reduced to 4 bits).
module tb_mux8_x0;

  localparam int CW = 4;

  logic          clk = 1'b0;
  bit            clk_run = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    sel = 3'd0;
  logic [7:0]    dat = 8'd0;
  logic          cnt_en = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          q, q_sync, cnt_ovf;
  logic [2:0]    sel_reg;
  logic [CW-1:0] edge_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: history of Q sampled at each edge, plus plain counters.
  bit qh[$];
  bit [2:0] m_sel;
  int m_cnt;
  bit m_ovf;

  mux8_x0 #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .S0(sel[0]), .S1(sel[1]), .S2(sel[2]),
    .A(dat[0]), .B(dat[1]), .C(dat[2]), .D(dat[3]),
    .E(dat[4]), .F(dat[5]), .G(dat[6]), .H(dat[7]),
    .Q(q), .CNT_EN(cnt_en), .CNT_CLR(cnt_clr),
    .Q_SYNC(q_sync), .SEL_REG(sel_reg), .EDGE_CNT(edge_cnt), .CNT_OVF(cnt_ovf)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic bit ref_mux(logic [7:0] d, logic [2:0] s);
    int k;
    k = int'(s);
    return bit'((int'(d) >> k) & 1);
  endfunction

  // Advance one clock: update the model from the inputs present at the edge.
  // qh holds {q_prev, Q_SYNC, stage1} as Q values sampled 3, 2, 1 edges ago.
  task automatic tick();
    bit qnow, rise;
    qnow = ref_mux(dat, sel);
    if (!rst_n) begin
      qh.delete();
      qh.push_back(1'b0); qh.push_back(1'b0); qh.push_back(1'b0);
      m_sel = 3'd0; m_cnt = 0; m_ovf = 1'b0;
    end else begin
      rise = (qh[1] == 1'b1) && (qh[0] == 1'b0);
      if (cnt_clr) begin
        m_cnt = 0; m_ovf = 1'b0;
      end else if (cnt_en && rise) begin
        if (m_cnt == (1 << CW) - 1) begin
          m_cnt = 0; m_ovf = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      m_sel = sel;
      void'(qh.pop_front());
      qh.push_back(qnow);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cnt_clr = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_a(int n);
    for (int p = 0; p < n; p++) begin
      dat[0] = 1'b1;
      repeat (4) tick();
      dat[0] = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic test_mux_exhaustive();
    bit exp_q[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    dat = 8'b1010_0110;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      checks++;
      if (q !== exp_q[s]) begin
        failures++;
        $display("FAIL mux_sweep sel=%0d got=%b want=%b", s, q, exp_q[s]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      dat = 8'($urandom); sel = 3'($urandom);
      #1;
      checks++;
      if (q !== ref_mux(dat, sel)) begin
        failures++;
        $display("FAIL mux_random dat=%h sel=%0d got=%b want=%b", dat, sel, q, ref_mux(dat, sel));
      end
    end
  endtask

  task automatic test_reset();
    dat = 8'hFF; sel = 3'd5; cnt_en = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({q_sync, sel_reg, edge_cnt, cnt_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_state got qs=%b sel=%0d cnt=%0d ovf=%b want all 0", q_sync, sel_reg, edge_cnt, cnt_ovf);
    end
    rst_n = 1'b1;
    dat = 8'h00; sel = 3'd0;
    repeat (4) tick();
  endtask

  task automatic test_latency();
    do_reset();
    dat = 8'h00; sel = 3'd0; cnt_en = 1'b1;
    repeat (3) tick();
    dat[0] = 1'b1;
    tick();
    checks++;
    if (q_sync !== 1'b0) begin
      failures++; $display("FAIL latency_edge1 qsync got=%b want=0", q_sync);
    end
    tick();
    checks++;
    if ({q_sync, edge_cnt} !== {1'b1, 4'd0}) begin
      failures++; $display("FAIL latency_edge2 got qs=%b cnt=%0d want qs=1 cnt=0", q_sync, edge_cnt);
    end
    tick();
    checks++;
    if (edge_cnt !== 4'd1) begin
      failures++; $display("FAIL latency_count got=%0d want=1", edge_cnt);
    end
    dat[0] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_counter_run();
    do_reset();
    dat = 8'h00; sel = 3'd0; cnt_en = 1'b1;
    repeat (3) tick();
    pulse_a(15);
    checks++;
    if ({edge_cnt, cnt_ovf} !== {4'd15, 1'b0}) begin
      failures++; $display("FAIL count15 got cnt=%0d ovf=%b want cnt=15 ovf=0", edge_cnt, cnt_ovf);
    end
    pulse_a(1);
    checks++;
    if ({edge_cnt, cnt_ovf} !== {4'd0, 1'b1}) begin
      failures++; $display("FAIL count16_wrap got cnt=%0d ovf=%b want cnt=0 ovf=1", edge_cnt, cnt_ovf);
    end
    pulse_a(1);
    checks++;
    if ({edge_cnt, cnt_ovf} !== {4'd1, 1'b1}) begin
      failures++; $display("FAIL count17 got cnt=%0d ovf=%b want cnt=1 ovf=1", edge_cnt, cnt_ovf);
    end
  endtask

  task automatic test_clear_priority();
    dat[0] = 1'b1;
    tick(); tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if ({edge_cnt, cnt_ovf} !== {4'd0, 1'b0}) begin
      failures++; $display("FAIL clear_priority got cnt=%0d ovf=%b want cnt=0 ovf=0", edge_cnt, cnt_ovf);
    end
    tick();
    checks++;
    if (edge_cnt !== 4'd0) begin
      failures++; $display("FAIL clear_hold got=%0d want=0", edge_cnt);
    end
    dat[0] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dat = 8'h00; sel = 3'd0; cnt_en = 1'b1;
    repeat (3) tick();
    pulse_a(5);
    checks++;
    if (edge_cnt !== 4'd5) begin
      failures++; $display("FAIL mid_precount got=%0d want=5", edge_cnt);
    end
    rst_n = 1'b0;
    dat = 8'($urandom); sel = 3'($urandom);
    tick();
    checks++;
    if ({q_sync, sel_reg, edge_cnt, cnt_ovf} !== '0) begin
      failures++;
      $display("FAIL mid_reset_regs got qs=%b sel=%0d cnt=%0d ovf=%b want all 0", q_sync, sel_reg, edge_cnt, cnt_ovf);
    end
    checks++;
    if (q !== ref_mux(dat, sel)) begin
      failures++; $display("FAIL q_during_reset got=%b want=%b", q, ref_mux(dat, sel));
    end
    // Q held high through reset release gives exactly one counted edge.
    dat = 8'h01; sel = 3'd0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({q_sync, edge_cnt} !== {1'b1, 4'd0}) begin
      failures++; $display("FAIL held_high_pre got qs=%b cnt=%0d want qs=1 cnt=0", q_sync, edge_cnt);
    end
    tick();
    checks++;
    if (edge_cnt !== 4'd1) begin
      failures++; $display("FAIL held_high_count got=%0d want=1", edge_cnt);
    end
    repeat (3) tick();
    checks++;
    if (edge_cnt !== 4'd1) begin
      failures++; $display("FAIL held_high_once got=%0d want=1", edge_cnt);
    end
    dat = 8'h00;
    repeat (4) tick();
  endtask

  task automatic test_enable_gating();
    logic [2:0] prev;
    do_reset();
    dat = 8'h00; cnt_en = 1'b0;
    repeat (3) tick();
    for (int ph = 0; ph < 40; ph++) begin
      if (ph == 24) cnt_en = 1'b1;
      dat = ((ph % 8) < 4) ? 8'hFF : 8'h00;
      sel = 3'($urandom);
      prev = sel;
      tick();
      checks++;
      if (sel_reg !== prev) begin
        failures++; $display("FAIL sel_track ph=%0d got=%0d want=%0d", ph, sel_reg, prev);
      end
      if (ph == 23) begin
        checks++;
        if (edge_cnt !== 4'd0) begin
          failures++; $display("FAIL gated_hold got=%0d want=0", edge_cnt);
        end
      end
    end
    checks++;
    if (edge_cnt !== 4'd2) begin
      failures++; $display("FAIL gated_count got=%0d want=2", edge_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n   = ($urandom_range(0, 59) != 0);
      cnt_clr = ($urandom_range(0, 29) == 0);
      cnt_en  = ($urandom_range(0, 3) != 0);
      sel     = 3'($urandom);
      if ($urandom_range(0, 2) == 0) dat = 8'($urandom);
      tick();
      checks++;
      if ({q, q_sync, sel_reg, edge_cnt, cnt_ovf} !==
          {ref_mux(dat, sel), qh[1], m_sel, m_cnt[CW-1:0], m_ovf}) begin
        failures++;
        $display("FAIL random i=%0d got q=%b qs=%b sel=%0d cnt=%0d ovf=%b want q=%b qs=%b sel=%0d cnt=%0d ovf=%b",
                 i, q, q_sync, sel_reg, edge_cnt, cnt_ovf,
                 ref_mux(dat, sel), qh[1], m_sel, m_cnt, m_ovf);
      end
    end
    rst_n = 1'b1; cnt_clr = 1'b0;
  endtask

  initial begin
    qh.push_back(1'b0); qh.push_back(1'b0); qh.push_back(1'b0);
    m_sel = 3'd0; m_cnt = 0; m_ovf = 1'b0;
    test_mux_exhaustive();
    clk_run = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_counter_run();
    test_clear_priority();
    test_reset_mid();
    test_enable_gating();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
